// File: rtl/seven_seg_scan_driver.sv
// seven_seg_scan_driver: time-multiplexed 7-segment scan driver with dead-time gap and leading-zero blanking
module seven_seg_scan_driver #(
    parameter int NUM_DIGITS     = 4,
    parameter int CLK_DIV        = 50000,
    parameter int GAP_CYCLES     = 16,
    parameter int LZ_BLANK       = 1,
    parameter int SEG_ACTIVE_LOW = 1,
    parameter int AN_ACTIVE_LOW  = 1
) (
    input  logic                                              clk,
    input  logic                                              rst,
    input  logic                                              Enable,
    input  logic                                              Load,
    input  logic [4*NUM_DIGITS-1:0]                           Data_in,
    input  logic [NUM_DIGITS-1:0]                             Dp_in,
    input  logic [NUM_DIGITS-1:0]                             Blank_in,
    output logic [6:0]                                        Seg_out,
    output logic                                              Dp_out,
    output logic [NUM_DIGITS-1:0]                             An_out,
    output logic [(NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1)-1:0] Digit_idx
);
    localparam int IW   = NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1;
    localparam int CMAX = CLK_DIV > GAP_CYCLES ? CLK_DIV : GAP_CYCLES;
    localparam int CW   = CMAX > 1 ? $clog2(CMAX) : 1;
    localparam logic [6:0]            SEG_OFF = SEG_ACTIVE_LOW != 0 ? 7'h7f : 7'h00;
    localparam logic                  DP_OFF  = SEG_ACTIVE_LOW != 0;
    localparam logic [NUM_DIGITS-1:0] AN_OFF  = AN_ACTIVE_LOW != 0 ? '1 : '0;

    typedef enum logic {SHOW, GAP} state_t;

    state_t                  state_q, state_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic [IW-1:0]           idx_q, idx_d, idx_nxt;
    logic [4*NUM_DIGITS-1:0] data_q;
    logic [NUM_DIGITS-1:0]   dp_q, blank_q, dark, an_hot, an_d;
    logic [6:0]              seg_q, seg_d;
    logic                    dp_out_q, dp_d;
    logic [NUM_DIGITS-1:0]   an_q;
    logic [3:0]              nib;
    logic                    cur_dark, cur_dp, zero_run, lit, last_show, last_gap;

    function automatic logic [6:0] decode(input logic [3:0] n);
        case (n)
            4'h0: decode = 7'b1000000;
            4'h1: decode = 7'b1111001;
            4'h2: decode = 7'b0100100;
            4'h3: decode = 7'b0110000;
            4'h4: decode = 7'b0011001;
            4'h5: decode = 7'b0010010;
            4'h6: decode = 7'b0000010;
            4'h7: decode = 7'b1111000;
            4'h8: decode = 7'b0000000;
            4'h9: decode = 7'b0010000;
            4'ha: decode = 7'b0001000;
            4'hb: decode = 7'b0000011;
            4'hc: decode = 7'b1000110;
            4'hd: decode = 7'b0100001;
            4'he: decode = 7'b0000110;
            default: decode = 7'b0001110;
        endcase
    endfunction

    // Dark mask (forced blank or leading zero) and the current digit's nibble/flags
    always_comb begin
        zero_run = 1'b1;
        dark     = '0;
        nib      = '0;
        cur_dark = 1'b1;
        cur_dp   = 1'b0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            zero_run = zero_run && (data_q[4*i +: 4] == 4'h0);
            dark[i]  = blank_q[i] || (LZ_BLANK != 0 && i > 0 && zero_run);
        end
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx_q == IW'(i)) begin
                nib      = data_q[4*i +: 4];
                cur_dark = dark[i];
                cur_dp   = dp_q[i];
            end
        end
    end

    // Next scan position and the output values for the current slot
    always_comb begin
        last_show = cnt_q == CW'(CLK_DIV - 1);
        last_gap  = cnt_q == CW'(GAP_CYCLES - 1);
        idx_nxt   = idx_q == IW'(NUM_DIGITS - 1) ? '0 : idx_q + IW'(1);
        state_d   = !Enable ? SHOW :
                    state_q == SHOW ? ((last_show && GAP_CYCLES > 0) ? GAP : SHOW) :
                    (last_gap ? SHOW : GAP);
        cnt_d     = !Enable ? '0 :
                    ((state_q == SHOW ? last_show : last_gap) ? '0 : cnt_q + CW'(1));
        idx_d     = (Enable && ((state_q == SHOW && last_show && GAP_CYCLES == 0) ||
                    (state_q == GAP && last_gap))) ? idx_nxt : idx_q;
        lit       = Enable && state_q == SHOW && !cur_dark;
        an_hot    = NUM_DIGITS'(1) << idx_q;
        an_d      = lit ? (AN_ACTIVE_LOW != 0 ? ~an_hot : an_hot) : AN_OFF;
        seg_d     = lit ? (SEG_ACTIVE_LOW != 0 ? decode(nib) : ~decode(nib)) : SEG_OFF;
        dp_d      = (lit && cur_dp) ? ~DP_OFF : DP_OFF;
    end

    // Scan FSM, shadow capture and registered pin outputs; reset overrides everything
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= SHOW;
            cnt_q    <= '0;
            idx_q    <= '0;
            data_q   <= '0;
            dp_q     <= '0;
            blank_q  <= '0;
            an_q     <= AN_OFF;
            seg_q    <= SEG_OFF;
            dp_out_q <= DP_OFF;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            an_q     <= an_d;
            seg_q    <= seg_d;
            dp_out_q <= dp_d;
            if (Load) begin
                data_q  <= Data_in;
                dp_q    <= Dp_in;
                blank_q <= Blank_in;
            end
        end
    end

    assign Seg_out   = seg_q;
    assign Dp_out    = dp_out_q;
    assign An_out    = an_q;
    assign Digit_idx = idx_q;
endmodule

// File: tb/tb_seven_seg_scan_driver.sv
// tb_seven_seg_scan_driver: randomized check of two driver configurations against a slot-timeline model
module tb_seven_seg_scan_driver;
    localparam int N  = 4;
    localparam int DA = 4, GA = 1;
    localparam int DB = 3, GB = 0;

    logic        clk = 1'b0;
    logic        rst, en, load;
    logic [15:0] data;
    logic [3:0]  dp, blank;
    logic [6:0]  a_seg, b_seg;
    logic        a_dp, b_dp;
    logic [3:0]  a_an, b_an;
    logic [1:0]  a_idx, b_idx;

    seven_seg_scan_driver #(.NUM_DIGITS(N), .CLK_DIV(DA), .GAP_CYCLES(GA), .LZ_BLANK(1),
                            .SEG_ACTIVE_LOW(1), .AN_ACTIVE_LOW(1)) dut_a (
        .clk(clk), .rst(rst), .Enable(en), .Load(load), .Data_in(data), .Dp_in(dp),
        .Blank_in(blank), .Seg_out(a_seg), .Dp_out(a_dp), .An_out(a_an), .Digit_idx(a_idx));

    seven_seg_scan_driver #(.NUM_DIGITS(N), .CLK_DIV(DB), .GAP_CYCLES(GB), .LZ_BLANK(0),
                            .SEG_ACTIVE_LOW(0), .AN_ACTIVE_LOW(0)) dut_b (
        .clk(clk), .rst(rst), .Enable(en), .Load(load), .Data_in(data), .Dp_in(dp),
        .Blank_in(blank), .Seg_out(b_seg), .Dp_out(b_dp), .An_out(b_an), .Digit_idx(b_idx));

    always #5 clk = ~clk;

    int n_checks = 0, n_errors = 0;
    logic [6:0] seg_tab [16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                                 7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                                 7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                                 7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
    int          ph [2];
    int          dg [2];
    logic [15:0] sd;
    logic [3:0]  sdp, sbl;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, obs, exp);
        end
    endtask

    function automatic bit dark(int d, bit lz);
        return sbl[d] || (lz && d > 0 && (sd >> (4 * d)) == 16'h0);
    endfunction

    task automatic step(input bit r, input bit e, input bit l, input logic [15:0] dt,
                        input logic [3:0] p, input logic [3:0] b);
        logic [6:0] eseg [2];
        logic [3:0] ean [2];
        logic       edp [2];
        int         cd, per, nb;
        bit         lit;
        @(negedge clk);
        rst = r; en = e; load = l; data = dt; dp = p; blank = b;
        @(posedge clk);
        for (int k = 0; k < 2; k++) begin
            cd  = k == 0 ? DA : DB;
            per = cd + (k == 0 ? GA : GB);
            lit = !r && e && ph[k] < cd && !dark(dg[k], k == 0);
            nb  = int'((sd >> (4 * dg[k])) & 16'hf);
            if (k == 0) begin
                ean[k]  = lit ? ~(4'b0001 << dg[k]) : 4'hf;
                eseg[k] = lit ? seg_tab[nb] : 7'h7f;
                edp[k]  = !(lit && sdp[dg[k]]);
            end else begin
                ean[k]  = lit ? (4'b0001 << dg[k]) : 4'h0;
                eseg[k] = lit ? ~seg_tab[nb] : 7'h00;
                edp[k]  = lit && sdp[dg[k]];
            end
            if (r) begin
                ph[k] = 0;
                dg[k] = 0;
            end else if (e) begin
                ph[k]++;
                if (ph[k] == per) begin
                    ph[k] = 0;
                    dg[k] = (dg[k] + 1) % N;
                end
            end else begin
                ph[k] = 0;
            end
        end
        if (r) begin
            sd = '0; sdp = '0; sbl = '0;
        end else if (l) begin
            sd = dt; sdp = p; sbl = b;
        end
        #1;
        check("a_an", a_an, ean[0]);
        check("a_seg", a_seg, eseg[0]);
        check("a_dp", a_dp, edp[0]);
        check("a_idx", a_idx, dg[0]);
        check("b_an", b_an, ean[1]);
        check("b_seg", b_seg, eseg[1]);
        check("b_dp", b_dp, edp[1]);
        check("b_idx", b_idx, dg[1]);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step(0, 1, 0, '0, '0, '0);
    endtask

    initial begin
        logic [15:0] mask;
        rst = 1'b1; en = 1'b0; load = 1'b0; data = '0; dp = '0; blank = '0;
        ph = '{0, 0}; dg = '{0, 0}; sd = '0; sdp = '0; sbl = '0;
        for (int i = 0; i < 3; i++) step(1, 1, 1, 16'($urandom), 4'($urandom), 4'($urandom));
        step(0, 1, 1, 16'h1234, 4'h0, 4'h0);
        run(45);
        for (int v = 0; v < 16; v++) begin
            step(0, 1, 1, 16'(v), 4'b0001, 4'h0);
            run(20);
        end
        step(0, 1, 1, 16'h0007, 4'h0, 4'h0);
        run(25);
        step(0, 1, 1, 16'h0000, 4'h0, 4'h0);
        run(25);
        step(0, 1, 1, 16'h0100, 4'hf, 4'h0);
        run(25);
        step(1, 1, 1, 16'h1234, 4'h0, 4'h0);
        run(6);
        step(0, 0, 0, '0, '0, '0);
        step(0, 0, 0, '0, '0, '0);
        run(12);
        step(1, 1, 0, '0, '0, '0);
        run(4);
        step(0, 1, 1, 16'h5678, 4'b0100, 4'b0001);
        run(40);
        for (int i = 0; i < 2500; i++) begin
            mask = 16'hffff >> (4 * $urandom_range(0, 4));
            step($urandom_range(0, 149) == 0, $urandom_range(0, 9) != 0, $urandom_range(0, 9) == 0,
                 16'($urandom) & mask, 4'($urandom),
                 $urandom_range(0, 3) == 0 ? 4'($urandom) : 4'h0);
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
